mc_ctrl: RTL and testbench
==========================

// Module: mc_ctrl
// PURPOSE
//  Multi-cycle control unit for the MIPS core: a sequencing FSM around a registered instruction decode.
//  Issues instruction/data memory requests with an ack handshake, and steps IDLE/FETCH/DECODE/EXEC/MEM/WB.
//  Produces one-cycle write strobes and holds the datapath control word stable from DECODE to retire.
//  Adds wait-state memory, branch resolution from ALU flags, illegal-opcode and bus-timeout detection.
// PARAMETERS
//  ALUCTR_W    4    width of alu_ctr; encodings unchanged from the single-cycle decoder, MSBs zero-filled
//  MEM_TIMEOUT 16   max cycles waiting for mem_ack in FETCH/MEM before bus_err (>=2)
//  CNT_W       5    width of wait counter; must satisfy 2**CNT_W > MEM_TIMEOUT
// PORTS
//  clk         in   1   rising-edge clock
//  rst_n       in   1   asynchronous active-low reset
//  run         in   1   1 = execute; 0 = park in IDLE at next instruction boundary
//  ins         in   32  memory read data; sampled as instruction when mem_ack in FETCH
//  mem_ack     in   1   memory handshake completion, valid only while mem_req=1
//  alu_zero    in   1   ALU result == 0 (EXEC)
//  alu_neg     in   1   ALU result sign / rs<0 (EXEC)
//  mem_req     out  1   memory request, held until mem_ack
//  mem_we      out  1   store qualifier for mem_req in MEM
//  ir_we       out  1   latch instruction register
//  pc_we       out  1   PC write strobe
//  pc_src      out  2   00 pc+4, 01 branch target, 10 jump target, 11 rs (jr/jalr)
//  reg_we      out  1   register file write strobe
//  reg_dst     out  2   {jal|jalr, Rtype}: 00 rt, 01 rd, 10/11 link
//  mem_to_reg  out  2   00 ALU, 01 load data, 10 link (pc+4)
//  alu_src_a   out  1   1 = shamt (sll/srl/sra)
//  alu_src_b   out  1   1 = extended immediate
//  ext_op      out  1   1 = sign-extend, 0 = zero-extend (andi/ori/xori/lui)
//  alu_ctr     out  ALUCTR_W  ALU operation
//  byte_mode   out  2   00 word, 01 lb, 10 sb, 11 lbu
//  state       out  3   current FSM state, for debug
//  busy        out  1   state != IDLE and state != HALT
//  illegal     out  1   one-cycle pulse on an unsupported opcode/funct
//  bus_err     out  1   sticky; set on memory timeout, cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE; every output is 0; control-word register and wait counter are 0.
//  States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
//  IDLE: outputs quiet; run=1 -> FETCH.
//  FETCH: mem_req=1, mem_we=0. When mem_ack=1: ir_we=1, pc_we=1, pc_src=00 -> DECODE.
//  DECODE (1 cycle): control word registered from ins; illegal encoding -> illegal=1 -> FETCH (or IDLE if run=0).
//  EXEC (1 cycle), ALU flags valid:
//   - beq: zero; bne: !zero; blez: zero|neg; bgtz: !zero&!neg.
//   - regimm: rt[0] ? !neg : neg.
//   - taken branch: pc_we=1, pc_src=01. j/jal: pc_src=10. jr/jalr: pc_src=11, pc_we=1.
//   - next state: load/store -> MEM; reg-writing -> WB; else retire.
//  MEM: mem_req=1, mem_we=store. On ack: load -> WB; store -> retire.
//  WB (1 cycle): reg_we=1 -> retire.
//  Retire: FETCH if run=1, else IDLE. run is sampled only at retire.
//  Cycles with zero-wait memory (ack in first req cycle):
//   - R/I ALU, jal, jalr: 4 cycles; lw/lb/lbu: 5; sw/sb: 4; branch, j, jr: 3.
//   - each wait cycle adds 1.
//  Wait counter: cleared on entry to FETCH/MEM; increments per un-acked cycle.
//   - at MEM_TIMEOUT un-acked cycles: bus_err=1, drop mem_req -> HALT.
//   - HALT is absorbing until rst_n.
//  mem_ack outside FETCH/MEM is ignored. Strobes (ir_we, pc_we, reg_we, illegal) never exceed one cycle per event.
//  rst_n low mid-instruction aborts immediately; no partial strobes are issued after reset.
//  Static control outputs (reg_dst, alu_*, ext_op, byte_mode, mem_to_reg) hold from DECODE+1 until the next DECODE.
// STRUCTURE
//  mc_ctrl_pkg: opcode/funct localparams, state encodings, pc_src and byte_mode encodings, control-word field layout.
//  Sub-module mc_decode: combinational ins -> control word + illegal/is_load/is_store/is_branch/writes_reg flags.
//  mc_ctrl contains the FSM, wait counter, control-word register and branch-condition logic.
// TESTING
//  1. addu $3,$1,$2 (0x00221821), ack on first cycle -> states 1,2,3,5; reg_we in cycle 4; reg_dst=01; retire in 4.
//  2. lw (0x8C430004), ack after 3 wait cycles in MEM -> mem_req held 4 cycles; mem_to_reg=01; reg_we once; total 8 cycles.
//  3. beq with alu_zero=1 -> pc_we twice (FETCH pc_src=00, EXEC pc_src=01). With alu_zero=0 -> EXEC pc_we=0.
//  4. jal 0x0C000010 -> EXEC pc_src=10; WB reg_we=1, reg_dst=1x, mem_to_reg=10.
//  5. opcode 0x3F -> illegal pulses 1 cycle in DECODE; no reg_we/mem_req; next state FETCH.
//  6. FETCH with mem_ack held 0 for MEM_TIMEOUT cycles -> bus_err=1, state=6, mem_req=0; stays until rst_n low.
//  7. run dropped mid-lw -> instruction completes, then IDLE. rst_n pulse in MEM -> all outputs 0, state=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes,
// functs, ALU operations and the registered control-word layout.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    // Control-flow class carried from DECODE into EXEC
    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_BEQ  = 4'd1,
        BR_BNE  = 4'd2,
        BR_BLEZ = 4'd3,
        BR_BGTZ = 4'd4,
        BR_BLTZ = 4'd5,
        BR_BGEZ = 4'd6,
        BR_JUMP = 4'd7,
        BR_JREG = 4'd8
    } br_t;

    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_JMP  = 2'b10;
    localparam logic [1:0] PC_RS   = 2'b11;

    localparam logic [1:0] BM_WORD = 2'b00;
    localparam logic [1:0] BM_LB   = 2'b01;
    localparam logic [1:0] BM_SB   = 2'b10;
    localparam logic [1:0] BM_LBU  = 2'b11;

    localparam logic [1:0] RD_RT     = 2'b00;
    localparam logic [1:0] RD_RD     = 2'b01;
    localparam logic [1:0] RD_LINK   = 2'b10;
    localparam logic [1:0] RD_LINK_R = 2'b11;

    localparam logic [1:0] MTR_ALU  = 2'b00;
    localparam logic [1:0] MTR_LOAD = 2'b01;
    localparam logic [1:0] MTR_LINK = 2'b10;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    typedef struct packed {
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       ext_op;
        logic [3:0] alu_ctr;
        logic [1:0] byte_mode;
        logic       is_load;
        logic       is_store;
        logic       writes_reg;
        br_t        br;
    } cw_t;

    localparam cw_t CW_NOP = '{
        reg_dst:    2'b00,
        mem_to_reg: 2'b00,
        alu_src_a:  1'b0,
        alu_src_b:  1'b0,
        ext_op:     1'b0,
        alu_ctr:    4'd0,
        byte_mode:  2'b00,
        is_load:    1'b0,
        is_store:   1'b0,
        writes_reg: 1'b0,
        br:         BR_NONE
    };

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decoder: maps an instruction word to the datapath
// control word and flags any unsupported opcode/funct combination.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [31:0] ins,
    output cw_t         cw,
    output logic        illegal
);

    logic [5:0] op_s;
    logic [5:0] funct_s;
    logic [4:0] rt_s;
    logic       unused_ins_s;

    assign op_s         = ins[31:26];
    assign rt_s         = ins[20:16];
    assign funct_s      = ins[5:0];
    assign unused_ins_s = ^{ins[25:21], ins[15:6]};

    // Opcode/funct decode; illegal encodings produce a quiet control word
    always_comb begin
        cw      = CW_NOP;
        illegal = 1'b0;
        case (op_s)
            OP_RTYPE: begin
                cw.reg_dst    = RD_RD;
                cw.writes_reg = 1'b1;
                case (funct_s)
                    FN_SLL:  begin cw.alu_src_a = 1'b1; cw.alu_ctr = ALU_SLL; end
                    FN_SRL:  begin cw.alu_src_a = 1'b1; cw.alu_ctr = ALU_SRL; end
                    FN_SRA:  begin cw.alu_src_a = 1'b1; cw.alu_ctr = ALU_SRA; end
                    FN_SLLV: cw.alu_ctr = ALU_SLL;
                    FN_SRLV: cw.alu_ctr = ALU_SRL;
                    FN_SRAV: cw.alu_ctr = ALU_SRA;
                    FN_ADD, FN_ADDU: cw.alu_ctr = ALU_ADD;
                    FN_SUB, FN_SUBU: cw.alu_ctr = ALU_SUB;
                    FN_AND:  cw.alu_ctr = ALU_AND;
                    FN_OR:   cw.alu_ctr = ALU_OR;
                    FN_XOR:  cw.alu_ctr = ALU_XOR;
                    FN_NOR:  cw.alu_ctr = ALU_NOR;
                    FN_SLT:  cw.alu_ctr = ALU_SLT;
                    FN_SLTU: cw.alu_ctr = ALU_SLTU;
                    FN_JR: begin
                        cw.reg_dst    = RD_RT;
                        cw.writes_reg = 1'b0;
                        cw.br         = BR_JREG;
                    end
                    FN_JALR: begin
                        cw.reg_dst    = RD_LINK_R;
                        cw.mem_to_reg = MTR_LINK;
                        cw.br         = BR_JREG;
                    end
                    default: begin
                        cw      = CW_NOP;
                        illegal = 1'b1;
                    end
                endcase
            end
            OP_REGIMM: begin
                // Only bltz (rt=0) and bgez (rt=1) are supported
                if (rt_s[4:1] == 4'd0) begin
                    cw.ext_op  = 1'b1;
                    cw.alu_ctr = ALU_SUB;
                    cw.br      = rt_s[0] ? BR_BGEZ : BR_BLTZ;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_J: cw.br = BR_JUMP;
            OP_JAL: begin
                cw.br         = BR_JUMP;
                cw.reg_dst    = RD_LINK;
                cw.mem_to_reg = MTR_LINK;
                cw.writes_reg = 1'b1;
            end
            OP_BEQ:  begin cw.ext_op = 1'b1; cw.alu_ctr = ALU_SUB; cw.br = BR_BEQ;  end
            OP_BNE:  begin cw.ext_op = 1'b1; cw.alu_ctr = ALU_SUB; cw.br = BR_BNE;  end
            OP_BLEZ: begin cw.ext_op = 1'b1; cw.alu_ctr = ALU_SUB; cw.br = BR_BLEZ; end
            OP_BGTZ: begin cw.ext_op = 1'b1; cw.alu_ctr = ALU_SUB; cw.br = BR_BGTZ; end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                cw.alu_src_b  = 1'b1;
                cw.writes_reg = 1'b1;
                case (op_s)
                    OP_ADDI, OP_ADDIU: begin cw.ext_op = 1'b1; cw.alu_ctr = ALU_ADD;  end
                    OP_SLTI:           begin cw.ext_op = 1'b1; cw.alu_ctr = ALU_SLT;  end
                    OP_SLTIU:          begin cw.ext_op = 1'b1; cw.alu_ctr = ALU_SLTU; end
                    OP_ANDI:           cw.alu_ctr = ALU_AND;
                    OP_ORI:            cw.alu_ctr = ALU_OR;
                    OP_XORI:           cw.alu_ctr = ALU_XOR;
                    default:           cw.alu_ctr = ALU_LUI;
                endcase
            end
            OP_LB, OP_LW, OP_LBU: begin
                cw.alu_src_b  = 1'b1;
                cw.ext_op     = 1'b1;
                cw.alu_ctr    = ALU_ADD;
                cw.is_load    = 1'b1;
                cw.writes_reg = 1'b1;
                cw.mem_to_reg = MTR_LOAD;
                case (op_s)
                    OP_LB:   cw.byte_mode = BM_LB;
                    OP_LBU:  cw.byte_mode = BM_LBU;
                    default: cw.byte_mode = BM_WORD;
                endcase
            end
            OP_SB, OP_SW: begin
                cw.alu_src_b = 1'b1;
                cw.ext_op    = 1'b1;
                cw.alu_ctr   = ALU_ADD;
                cw.is_store  = 1'b1;
                cw.byte_mode = (op_s == OP_SB) ? BM_SB : BM_WORD;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: sequencing FSM with memory handshake and
// timeout, registered control word, and branch resolution from ALU flags.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTR_W    = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [31:0]         ins,
    input  logic                mem_ack,
    input  logic                alu_zero,
    input  logic                alu_neg,
    output logic                mem_req,
    output logic                mem_we,
    output logic                ir_we,
    output logic                pc_we,
    output logic [1:0]          pc_src,
    output logic                reg_we,
    output logic [1:0]          reg_dst,
    output logic [1:0]          mem_to_reg,
    output logic                alu_src_a,
    output logic                alu_src_b,
    output logic                ext_op,
    output logic [ALUCTR_W-1:0] alu_ctr,
    output logic [1:0]          byte_mode,
    output logic [2:0]          state,
    output logic                busy,
    output logic                illegal,
    output logic                bus_err
);

    state_t             state_r;
    state_t             state_n_s;
    logic [31:0]        ir_r;
    cw_t                cw_r;
    cw_t                dec_cw_s;
    logic               dec_illegal_s;
    logic [CNT_W-1:0]   wait_cnt_r;
    logic               bus_err_r;
    logic               at_limit_s;
    logic               cnt_inc_s;
    logic               timeout_s;
    logic               taken_s;
    state_t             retire_s;

    mc_ctrl_decode u_decode (
        .ins     (ir_r),
        .cw      (dec_cw_s),
        .illegal (dec_illegal_s)
    );

    assign at_limit_s = (wait_cnt_r == CNT_W'(MEM_TIMEOUT - 1));

    // Branch condition from the ALU flags of the instruction in EXEC
    always_comb begin
        taken_s = 1'b0;
        case (cw_r.br)
            BR_BEQ:  taken_s = alu_zero;
            BR_BNE:  taken_s = !alu_zero;
            BR_BLEZ: taken_s = alu_zero | alu_neg;
            BR_BGTZ: taken_s = !alu_zero & !alu_neg;
            BR_BLTZ: taken_s = alu_neg;
            BR_BGEZ: taken_s = !alu_neg;
            default: taken_s = 1'b0;
        endcase
    end

    // Next state, handshake and one-cycle strobes
    always_comb begin
        state_n_s = state_r;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = PC_SEQ;
        reg_we    = 1'b0;
        illegal   = 1'b0;
        cnt_inc_s = 1'b0;
        timeout_s = 1'b0;
        retire_s  = run ? S_FETCH : S_IDLE;
        case (state_r)
            S_IDLE: begin
                if (run) begin
                    state_n_s = S_FETCH;
                end else begin
                    state_n_s = S_IDLE;
                end
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we     = 1'b1;
                    pc_we     = 1'b1;
                    state_n_s = S_DECODE;
                end else if (at_limit_s) begin
                    timeout_s = 1'b1;
                    state_n_s = S_HALT;
                end else begin
                    cnt_inc_s = 1'b1;
                end
            end
            S_DECODE: begin
                if (dec_illegal_s) begin
                    illegal   = 1'b1;
                    state_n_s = retire_s;
                end else begin
                    state_n_s = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cw_r.br == BR_JUMP) begin
                    pc_we  = 1'b1;
                    pc_src = PC_JMP;
                end else if (cw_r.br == BR_JREG) begin
                    pc_we  = 1'b1;
                    pc_src = PC_RS;
                end else if (taken_s) begin
                    pc_we  = 1'b1;
                    pc_src = PC_BR;
                end else begin
                    pc_we  = 1'b0;
                end
                if (cw_r.is_load || cw_r.is_store) begin
                    state_n_s = S_MEM;
                end else if (cw_r.writes_reg) begin
                    state_n_s = S_WB;
                end else begin
                    state_n_s = retire_s;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = cw_r.is_store;
                if (mem_ack) begin
                    state_n_s = cw_r.is_load ? S_WB : retire_s;
                end else if (at_limit_s) begin
                    timeout_s = 1'b1;
                    state_n_s = S_HALT;
                end else begin
                    cnt_inc_s = 1'b1;
                end
            end
            S_WB: begin
                reg_we    = 1'b1;
                state_n_s = retire_s;
            end
            S_HALT: state_n_s = S_HALT;
            default: state_n_s = S_IDLE;
        endcase
    end

    // FSM state, wait counter and sticky bus error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            wait_cnt_r <= {CNT_W{1'b0}};
            bus_err_r  <= 1'b0;
        end else begin
            state_r <= state_n_s;
            if (timeout_s) begin
                bus_err_r <= 1'b1;
            end
            // Any exit from a request state leaves the counter at zero for the next one
            if (cnt_inc_s) begin
                wait_cnt_r <= wait_cnt_r + CNT_W'(1);
            end else begin
                wait_cnt_r <= {CNT_W{1'b0}};
            end
        end
    end

    // Instruction register and control word held from DECODE+1 to the next DECODE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_r <= 32'd0;
            cw_r <= CW_NOP;
        end else begin
            if (state_r == S_FETCH && mem_ack) begin
                ir_r <= ins;
            end
            if (state_r == S_DECODE) begin
                cw_r <= dec_cw_s;
            end
        end
    end

    assign reg_dst    = cw_r.reg_dst;
    assign mem_to_reg = cw_r.mem_to_reg;
    assign alu_src_a  = cw_r.alu_src_a;
    assign alu_src_b  = cw_r.alu_src_b;
    assign ext_op     = cw_r.ext_op;
    assign alu_ctr    = ALUCTR_W'(cw_r.alu_ctr);
    assign byte_mode  = cw_r.byte_mode;
    assign state      = state_r;
    assign busy       = (state_r != S_IDLE) && (state_r != S_HALT);
    assign bus_err    = bus_err_r;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl: instruction sequences with
// hand-computed state/strobe expectations, timeout and reset abort.
module tb_mc_ctrl;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [31:0] ins;
    logic        mem_ack;
    logic        alu_zero;
    logic        alu_neg;
    logic        mem_req;
    logic        mem_we;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        reg_we;
    logic [1:0]  reg_dst;
    logic [1:0]  mem_to_reg;
    logic        alu_src_a;
    logic        alu_src_b;
    logic        ext_op;
    logic [3:0]  alu_ctr;
    logic [1:0]  byte_mode;
    logic [2:0]  state;
    logic        busy;
    logic        illegal;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    mc_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .ins        (ins),
        .mem_ack    (mem_ack),
        .alu_zero   (alu_zero),
        .alu_neg    (alu_neg),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ext_op     (ext_op),
        .alu_ctr    (alu_ctr),
        .byte_mode  (byte_mode),
        .state      (state),
        .busy       (busy),
        .illegal    (illegal),
        .bus_err    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then apply this cycle's memory/ALU inputs and let them settle
    task automatic step(input logic a, input logic z, input logic n);
        @(posedge clk);
        #1;
        mem_ack  = a;
        alu_zero = z;
        alu_neg  = n;
        #1;
    endtask

    function automatic logic [31:0] all_outs();
        return {6'd0, state, mem_req, mem_we, ir_we, pc_we, pc_src, reg_we, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, ext_op, alu_ctr, byte_mode,
                busy, illegal, bus_err};
    endfunction

    initial begin
        rst_n = 1'b0; run = 1'b0; ins = 32'd0;
        mem_ack = 1'b0; alu_zero = 1'b0; alu_neg = 1'b0;
        #12;
        chk("reset_outputs", all_outs(), 32'd0);
        rst_n = 1'b1;
        run   = 1'b1;

        // addu $3,$1,$2: FETCH, DECODE, EXEC, WB
        ins = 32'h0022_1821;
        step(1'b1, 1'b0, 1'b0);
        chk("addu_fetch_state", state, 32'd1);
        chk("addu_fetch_req", mem_req, 32'd1);
        chk("addu_fetch_irwe", ir_we, 32'd1);
        chk("addu_fetch_pcwe", {pc_we, pc_src}, {29'd0, 3'b100});
        chk("addu_busy", busy, 32'd1);
        step(1'b0, 1'b0, 1'b0);
        chk("addu_decode", {state, illegal, ir_we, mem_req}, {26'd0, 3'd2, 3'b000});
        step(1'b0, 1'b0, 1'b0);
        chk("addu_exec", {state, pc_we, reg_we}, {27'd0, 3'd3, 2'b00});
        chk("addu_regdst", reg_dst, 32'd1);
        chk("addu_mtr", mem_to_reg, 32'd0);
        step(1'b0, 1'b0, 1'b0);
        chk("addu_wb", {state, reg_we}, {28'd0, 3'd5, 1'b1});

        // lw with three wait states in MEM; run dropped mid-instruction
        ins = 32'h8C43_0004;
        step(1'b1, 1'b0, 1'b0);
        chk("addu_retire_fetch", {state, ir_we}, {28'd0, 3'd1, 1'b1});
        step(1'b0, 1'b0, 1'b0);
        chk("lw_decode", state, 32'd2);
        step(1'b0, 1'b0, 1'b0);
        chk("lw_exec", state, 32'd3);
        chk("lw_ctl", {mem_to_reg, alu_src_b, ext_op, byte_mode}, {26'd0, 2'b01, 1'b1, 1'b1, 2'b00});
        step(1'b0, 1'b0, 1'b0);
        chk("lw_mem1", {state, mem_req, mem_we}, {27'd0, 3'd4, 2'b10});
        run = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        chk("lw_mem2", {state, mem_req}, {28'd0, 3'd4, 1'b1});
        step(1'b0, 1'b0, 1'b0);
        chk("lw_mem3", {state, mem_req}, {28'd0, 3'd4, 1'b1});
        step(1'b1, 1'b0, 1'b0);
        chk("lw_mem4_ack", {state, mem_req, reg_we}, {27'd0, 3'd4, 2'b10});
        step(1'b0, 1'b0, 1'b0);
        chk("lw_wb", {state, reg_we, mem_req}, {27'd0, 3'd5, 2'b10});
        step(1'b0, 1'b0, 1'b0);
        chk("lw_idle", {state, reg_we, busy}, {27'd0, 3'd0, 2'b00});
        chk("lw_hold_mtr", mem_to_reg, 32'd1);
        step(1'b1, 1'b0, 1'b0);
        chk("idle_stays", {state, mem_req, ir_we}, {27'd0, 3'd0, 2'b00});

        // beq taken, then beq not taken, then bltz taken
        run = 1'b1;
        ins = 32'h1022_0004;
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("beq_fetch", {state, pc_we, pc_src}, {26'd0, 3'd1, 1'b1, 2'b00});
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("beq_taken", {state, pc_we, pc_src}, {26'd0, 3'd3, 1'b1, 2'b01});
        step(1'b1, 1'b0, 1'b0);
        chk("beq_retire3", state, 32'd1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("beq_not_taken", {state, pc_we}, {28'd0, 3'd3, 1'b0});
        ins = 32'h0420_0003;
        step(1'b1, 1'b0, 1'b0);
        chk("bltz_fetch", state, 32'd1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("bltz_taken", {state, pc_we, pc_src}, {26'd0, 3'd3, 1'b1, 2'b01});

        // jal: jump target in EXEC, link write in WB
        ins = 32'h0C00_0010;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("jal_exec", {state, pc_we, pc_src}, {26'd0, 3'd3, 1'b1, 2'b10});
        step(1'b0, 1'b0, 1'b0);
        chk("jal_wb", {state, reg_we, reg_dst, mem_to_reg}, {24'd0, 3'd5, 1'b1, 2'b10, 2'b10});

        // sb: store with immediate ack retires straight to FETCH
        ins = 32'hA043_0004;
        step(1'b1, 1'b0, 1'b0);
        chk("jal_regdst_hold", {state, reg_dst}, {27'd0, 3'd1, 2'b10});
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("sb_exec", {state, pc_we, byte_mode}, {26'd0, 3'd3, 1'b0, 2'b10});
        step(1'b1, 1'b0, 1'b0);
        chk("sb_mem", {state, mem_req, mem_we, reg_we}, {26'd0, 3'd4, 3'b110});

        // Illegal opcode 0x3F
        ins = 32'hFC00_0000;
        step(1'b1, 1'b0, 1'b0);
        chk("sb_retire_fetch", {state, ir_we}, {28'd0, 3'd1, 1'b1});
        step(1'b0, 1'b0, 1'b0);
        chk("ill_decode", {state, illegal, mem_req, reg_we}, {26'd0, 3'd2, 3'b100});
        step(1'b0, 1'b0, 1'b0);
        chk("ill_next_fetch", {state, illegal}, {28'd0, 3'd1, 1'b0});

        // Fetch timeout: MEM_TIMEOUT un-acked request cycles, then HALT
        for (int i = 0; i < 16; i++) begin
            chk("to_fetch_wait", {state, mem_req, bus_err}, {27'd0, 3'd1, 2'b10});
            step(1'b0, 1'b0, 1'b0);
        end
        chk("to_halt", {state, mem_req, bus_err, busy}, {26'd0, 3'd6, 3'b010});
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("halt_absorbing", {state, ir_we, bus_err}, {27'd0, 3'd6, 2'b01});
        rst_n = 1'b0;
        #1;
        chk("halt_reset", all_outs(), 32'd0);
        #2;
        rst_n = 1'b1;

        // Reset pulse while a load sits in MEM
        ins = 32'h8C43_0004;
        step(1'b1, 1'b0, 1'b0);
        chk("lw2_fetch", state, 32'd1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("lw2_mem", {state, mem_req}, {28'd0, 3'd4, 1'b1});
        rst_n = 1'b0;
        #1;
        chk("mem_reset", all_outs(), 32'd0);
        #2;
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
